// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, request type and check helpers for dmem_responder
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef struct packed {
        logic        we;
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Access size lives in func3[1:0] for both loads and stores.
    function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] offset);
        case (func3[1:0])
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = (offset != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic illegal_func3(input logic we, input logic [2:0] func3);
        if (we)
            illegal_func3 = (func3 > F3_W);
        else
            illegal_func3 = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response channel between datapath and dmem_responder
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_lsu_align.sv
// rtl/dmem_lsu_align.sv - byte-lane extraction/extension for loads, lane steering for stores
module dmem_lsu_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [3:0]  be,
    output logic [31:0] st_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];

        case (func3)
            F3_B:    ld_data = {{24{lane_b[7]}}, lane_b};
            F3_H:    ld_data = {{16{lane_h[15]}}, lane_h};
            F3_W:    ld_data = word;
            F3_BU:   ld_data = {24'd0, lane_b};
            F3_HU:   ld_data = {16'd0, lane_h};
            default: ld_data = 32'd0;
        endcase
    end

    // Store data is replicated across lanes; the byte enable picks the live ones.
    always_comb begin
        be      = 4'b0000;
        st_data = wdata;
        case (func3)
            F3_B: begin
                be      = 4'b0001 << offset;
                st_data = {4{wdata[7:0]}};
            end
            F3_H: begin
                be      = offset[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            F3_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data memory responder; DMEM_BACK_TO_BACK_EN overlaps accept with response
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic             clk,
    input logic             rst_n,
    dmem_responder_if.slave bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [1:0]  state;
    logic [3:0]  cnt;
    req_t        in_req, lat_req, cmt_req;
    logic        accept, enter_resp, cmt_err;
    logic [31:0] word_idx, rd_word, ld_data, st_data;
    logic [3:0]  be;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem [DEPTH_WORDS];

    assign in_req = '{we: bus.req_we, func3: bus.req_func3, addr: bus.req_addr, wdata: bus.req_wdata};

`ifdef DMEM_BACK_TO_BACK_EN
    assign bus.req_ready = (state == S_IDLE) || ((state == S_RESP) && bus.rsp_ready);
`else
    assign bus.req_ready = (state == S_IDLE);
`endif

    assign accept     = bus.req_valid && bus.req_ready;
    assign enter_resp = (accept && (LATENCY == 1)) || ((state == S_WAIT) && (cnt == 4'd1));

    // With single-cycle latency the commit edge is the accept edge, so use the live request.
    assign cmt_req  = (LATENCY == 1) ? in_req : lat_req;
    assign word_idx = {2'b00, cmt_req.addr[31:2]};
    assign cmt_err  = misaligned(cmt_req.func3, cmt_req.addr[1:0])
                    || illegal_func3(cmt_req.we, cmt_req.func3)
                    || (word_idx >= 32'(DEPTH_WORDS));
    assign rd_word  = mem[word_idx[AW-1:0]];

    dmem_lsu_align u_align (
        .word    (rd_word),
        .offset  (cmt_req.addr[1:0]),
        .func3   (cmt_req.func3),
        .wdata   (cmt_req.wdata),
        .ld_data (ld_data),
        .be      (be),
        .st_data (st_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            lat_req     <= '0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                lat_req <= in_req;
                state   <= (LATENCY == 1) ? S_RESP : S_WAIT;
                cnt     <= 4'(LATENCY - 1);
            end else begin
                case (state)
                    S_WAIT: begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1)
                            state <= S_RESP;
                    end
                    S_RESP: if (bus.rsp_ready) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
            if (enter_resp) begin
                rsp_err_q   <= cmt_err;
                rsp_rdata_q <= (cmt_err || cmt_req.we) ? 32'd0 : ld_data;
            end
        end
    end

    // The array has no reset; gating on rst_n drops any commit while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && cmt_req.we && !cmt_err) begin
            for (int b = 0; b < 4; b++)
                if (be[b])
                    mem[word_idx[AW-1:0]][8*b +: 8] <= st_data[8*b +: 8];
        end
    end

    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_func3 = f3;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    task automatic issue(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        drive(we, f3, addr, wdata);
        chk({tag, ".req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Called just after the accept edge; request cycle counts as cycle 0.
    task automatic wait_rsp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
        int n = 1;
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            n++;
        end
        if (!seen)
            chk({tag, ".rsp_valid_timeout"}, {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, ".latency"}, n, LAT);
        chk({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
        chk({tag, ".err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
        chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        issue(tag, we, f3, addr, wdata);
        wait_rsp(tag, exp_rdata, exp_err);
        chk({tag, ".req_ready_in_resp"}, {31'd0, bus.req_ready}, 32'd0);
        consume();
        @(negedge clk);
        chk({tag, ".busy_after"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_func3 = 3'b000;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;

        #1;
        chk("reset.req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset.rdata",     bus.rsp_rdata, 32'd0);
        chk("reset.err",       {31'd0, bus.rsp_err}, 32'd0);
        chk("reset.busy",      {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        txn("sw10",   1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        txn("lw10",   1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        txn("lb13",   1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
        txn("lbu13",  1'b0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0);
        txn("lh10",   1'b0, F3_H,  32'h10, 32'h0,        32'hFFFFBEEF, 1'b0);
        txn("lhu12",  1'b0, F3_HU, 32'h12, 32'h0,        32'h0000DEAD, 1'b0);
        txn("sb11",   1'b1, F3_B,  32'h11, 32'h00000055, 32'h0,        1'b0);
        txn("lw10b",  1'b0, F3_W,  32'h10, 32'h0,        32'hDEAD55EF, 1'b0);
        txn("lb11",   1'b0, F3_B,  32'h11, 32'h0,        32'h00000055, 1'b0);
        txn("lb10",   1'b0, F3_B,  32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);
        txn("lw12",   1'b0, F3_W,  32'h12, 32'h0,        32'h0,        1'b1);
        txn("sw20",   1'b1, F3_W,  32'h20, 32'h12345678, 32'h0,        1'b0);
        txn("sh21",   1'b1, F3_H,  32'h21, 32'h0000AAAA, 32'h0,        1'b1);
        txn("lw20",   1'b0, F3_W,  32'h20, 32'h0,        32'h12345678, 1'b0);
        txn("lw_oor", 1'b0, F3_W,  32'h1000, 32'h0,      32'h0,        1'b1);
        txn("ld_f3_3",1'b0, 3'b011, 32'h20, 32'h0,       32'h0,        1'b1);
        txn("st_f3_4",1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0,       1'b1);
        txn("lw20b",  1'b0, F3_W,  32'h20, 32'h0,        32'h12345678, 1'b0);
        txn("sh22",   1'b1, F3_H,  32'h22, 32'h00008001, 32'h0,        1'b0);
        txn("lw20c",  1'b0, F3_W,  32'h20, 32'h0,        32'h80015678, 1'b0);
        txn("lh22",   1'b0, F3_H,  32'h22, 32'h0,        32'hFFFF8001, 1'b0);
        txn("lhu22",  1'b0, F3_HU, 32'h22, 32'h0,        32'h00008001, 1'b0);

        // Response stall with a second request held by the initiator.
        issue("hold", 1'b0, F3_W, 32'h20, 32'h0);
        drive(1'b0, F3_W, 32'h10, 32'h0);
        wait_rsp("hold", 32'h80015678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold.rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("hold.rdata",     bus.rsp_rdata, 32'h80015678);
            chk("hold.busy",      {31'd0, bus.busy}, 32'd1);
            chk("hold.req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
`ifdef DMEM_BACK_TO_BACK_EN
        #1 chk("b2b.req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 begin
            bus.rsp_ready = 1'b0;
            bus.req_valid = 1'b0;
        end
        wait_rsp("b2b", 32'hDEAD55EF, 1'b0);
`else
        #1 chk("held.req_ready", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("held.idle_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("held.idle_busy",  {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_rsp("held", 32'hDEAD55EF, 1'b0);
`endif
        consume();

        // Reset during WAIT discards the pending store.
        txn("sw30",  1'b1, F3_W, 32'h30, 32'hCAFEF00D, 32'h0,        1'b0);
        txn("lw30",  1'b0, F3_W, 32'h30, 32'h0,        32'hCAFEF00D, 1'b0);
        issue("sw30_abort", 1'b1, F3_W, 32'h30, 32'h11111111);
        @(negedge clk);
        chk("abort.busy_wait", {31'd0, bus.busy}, 32'd1);
        chk("abort.valid_wait", {31'd0, bus.rsp_valid}, 32'd0);
        chk("abort.rdata_pre", bus.rsp_rdata, 32'hCAFEF00D);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("abort.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("abort.busy",      {31'd0, bus.busy}, 32'd0);
        chk("abort.rdata",     bus.rsp_rdata, 32'd0);
        chk("abort.err",       {31'd0, bus.rsp_err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        txn("lw30b", 1'b0, F3_W, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
